// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the sequential divider.
//   state_t           : divider FSM states (IDLE, RUN, FIX, DONE)
//   ITER_COUNT        : number of non-restoring iterations per division
//   DIV_ZERO_QUOTIENT : quotient reported for a zero divisor
package div_pkg;
   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
   localparam int ITER_COUNT = 32;
   localparam logic [31:0] DIV_ZERO_QUOTIENT = 32'hFFFF_FFFF;
endpackage

// File: rtl/addsub_w.sv
// addsub_w: WIDTH+1 bit ripple-carry adder/subtractor, o_sum = i_a + (i_b ^ {i_sub}) + i_sub.
//   i_a, i_b : operands (WIDTH+1 bits)
//   i_sub    : 1 = subtract (inverts i_b, carry-in 1), 0 = add
//   o_sum    : result (WIDTH+1 bits)
//   o_c_out  : carry out of the top bit
module addsub_w #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0] i_a,
   input  logic [WIDTH:0] i_b,
   input  logic           i_sub,
   output logic [WIDTH:0] o_sum,
   output logic           o_c_out
);
   logic [WIDTH+1:0] w_c;
   logic [WIDTH:0]   w_b;
   always_comb begin
      w_b    = i_b ^ {(WIDTH+1){i_sub}};
      w_c    = '0;
      w_c[0] = i_sub;
      o_sum  = '0;
      for (int k = 0; k <= WIDTH; k++) begin
         o_sum[k]   = i_a[k] ^ w_b[k] ^ w_c[k];
         w_c[k+1]   = (i_a[k] & w_b[k]) | (w_c[k] & (i_a[k] ^ w_b[k]));
      end
      o_c_out = w_c[WIDTH+1];
   end
endmodule

// File: rtl/div_seq.sv
// div_seq: multi-cycle 32-bit non-restoring divider (quotient -> LO, remainder -> HI).
//   i_clk, i_rst_n            : rising-edge clock, asynchronous active-low reset
//   i_start                   : start a division (sampled only in IDLE)
//   i_dividend, i_divisor     : operands, captured on an accepted start
//   o_busy                    : high in RUN and FIX
//   o_done                    : one-cycle pulse, results valid from this cycle
//   o_quotient, o_remainder   : results, held until the next division completes
//   o_div_zero                : divisor was zero; cleared by the next accepted start
// Build option: define DIV_SIGNED_EN for two's complement operands (default unsigned).
module div_seq
   import div_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_dividend,
   input  logic [WIDTH-1:0] i_divisor,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_quotient,
   output logic [WIDTH-1:0] o_remainder,
   output logic             o_div_zero
);
   localparam int CW = $clog2(ITER_COUNT);
   localparam logic [CW-1:0] LAST = CW'(ITER_COUNT - 1);

   state_t           r_state, w_state_next;
   logic [WIDTH:0]   r_p, r_d;
   logic [WIDTH-1:0] r_q;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_quotient, r_remainder;
   logic             r_div_zero;

   logic             w_accept, w_dz;
   logic [WIDTH-1:0] w_dvd_mag, w_dsr_mag, w_quot_fix, w_rem_fix, w_rem;
   logic [WIDTH:0]   w_a, w_b, w_sum;
   logic             w_sub, w_unused_c_out;

   assign w_accept = (r_state == IDLE) && i_start;
   assign w_dz     = (i_divisor == '0);
   assign w_rem    = w_sum[WIDTH-1:0];

   // One shared adder: RUN shifts P:Q in and adds or subtracts D by the sign of the old P;
   // FIX adds D back only when the partial remainder ended negative.
   assign w_a   = (r_state == RUN) ? {r_p[WIDTH-1:0], r_q[WIDTH-1]} : r_p;
   assign w_b   = ((r_state == RUN) || r_p[WIDTH]) ? r_d : '0;
   assign w_sub = (r_state == RUN) && !r_p[WIDTH];

   addsub_w #(.WIDTH(WIDTH)) u_addsub (
      .i_a     (w_a),
      .i_b     (w_b),
      .i_sub   (w_sub),
      .o_sum   (w_sum),
      .o_c_out (w_unused_c_out)
   );

`ifdef DIV_SIGNED_EN
   logic r_sign_q, r_sign_r;
   assign w_dvd_mag  = i_dividend[WIDTH-1] ? -i_dividend : i_dividend;
   assign w_dsr_mag  = i_divisor[WIDTH-1]  ? -i_divisor  : i_divisor;
   assign w_quot_fix = r_sign_q ? -r_q   : r_q;
   assign w_rem_fix  = r_sign_r ? -w_rem : w_rem;
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sign_q <= 1'b0;
         r_sign_r <= 1'b0;
      end else if (w_accept) begin
         r_sign_q <= i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1];
         r_sign_r <= i_dividend[WIDTH-1];
      end
   end
`else
   assign w_dvd_mag  = i_dividend;
   assign w_dsr_mag  = i_divisor;
   assign w_quot_fix = r_q;
   assign w_rem_fix  = w_rem;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= IDLE;
      else          r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      o_busy       = 1'b0;
      o_done       = 1'b0;
      case (r_state)
         IDLE: if (i_start) w_state_next = w_dz ? DONE : RUN;
         RUN: begin
            o_busy = 1'b1;
            if (r_cnt == LAST) w_state_next = FIX;
         end
         FIX: begin
            o_busy       = 1'b1;
            w_state_next = DONE;
         end
         DONE: begin
            o_done       = 1'b1;
            w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_p         <= '0;
         r_d         <= '0;
         r_q         <= '0;
         r_cnt       <= '0;
         r_quotient  <= '0;
         r_remainder <= '0;
         r_div_zero  <= 1'b0;
      end else if (w_accept) begin
         r_p        <= '0;
         r_d        <= {1'b0, w_dsr_mag};
         r_q        <= w_dvd_mag;
         r_cnt      <= '0;
         r_div_zero <= w_dz;
         if (w_dz) begin
            r_quotient  <= DIV_ZERO_QUOTIENT;
            r_remainder <= i_dividend;
         end
      end else if (r_state == RUN) begin
         r_p   <= w_sum;
         r_q   <= {r_q[WIDTH-2:0], ~w_sum[WIDTH]};
         r_cnt <= r_cnt + 1'b1;
      end else if (r_state == FIX) begin
         r_p         <= w_sum;
         r_quotient  <= w_quot_fix;
         r_remainder <= w_rem_fix;
      end
   end

   assign o_quotient  = r_quotient;
   assign o_remainder = r_remainder;
   assign o_div_zero  = r_div_zero;
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: self-checking bench for div_seq (vector table, scoreboard queue, corner sequences).
module tb_div_seq;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] dvd = '0, dsr = '0;
   logic        busy, done, dz;
   logic [31:0] quo, rem;

   always #5 clk = ~clk;

   div_seq #(.WIDTH(32)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_start     (start),
      .i_dividend  (dvd),
      .i_divisor   (dsr),
      .o_busy      (busy),
      .o_done      (done),
      .o_quotient  (quo),
      .o_remainder (rem),
      .o_div_zero  (dz)
   );

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      logic        z;
   } exp_t;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] q;
      logic [31:0] r;
      logic        z;
      int          lat;
   } vec_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic launch(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] q, input logic [31:0] r, input logic z);
      exp_t e;
      e.q = q;
      e.r = r;
      e.z = z;
      dvd   = a;
      dsr   = b;
      start = 1'b1;
      sb.push_back(e);
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(input int exp_lat, input int lat0, input string tag);
      int   lat;
      exp_t e;
      lat = lat0;
      while (!done && lat < 100) begin
         @(posedge clk);
         #1 lat++;
      end
      chk({tag, " latency"}, lat, exp_lat);
      if (sb.size() == 0) begin
         chk({tag, " scoreboard entry"}, 0, 1);
      end else begin
         e = sb.pop_front();
         if (done) begin
            chk({tag, " busy at done"}, 32'(busy), 0);
            chk({tag, " quotient"}, quo, e.q);
            chk({tag, " remainder"}, rem, e.r);
            chk({tag, " div_zero"}, 32'(dz), 32'(e.z));
         end
      end
      @(posedge clk);
      #1 chk({tag, " done single pulse"}, 32'(done), 0);
   endtask

   initial begin
      vec_t vecs[$];
      int   seen;
`ifdef DIV_SIGNED_EN
      vecs = '{
         '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 34},
         '{32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678,  1'b1, 1},
         '{32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 34},
         '{32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 34},
         '{32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0, 34},
         '{32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0, 34},
         '{32'd5,          32'd9,          32'd0,          32'd5,          1'b0, 34},
         '{32'hFFFF_FFFE,  32'hFFFF_FFFF,  32'd2,          32'd0,          1'b0, 34}
      };
`else
      vecs = '{
         '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 34},
         '{32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678,  1'b1, 1},
         '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 34},
         '{32'd5,          32'd9,          32'd0,          32'd5,          1'b0, 34},
         '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0, 34},
         '{32'hFFFF_FFFE,  32'hFFFF_FFFF,  32'd0,          32'hFFFF_FFFE,  1'b0, 34},
         '{32'd1000000,    32'd1000,       32'd1000,       32'd0,          1'b0, 34},
         '{32'hDEAD_BEEF,  32'h10,         32'h0DEA_DBEE,  32'hF,          1'b0, 34},
         '{32'h8000_0000,  32'd3,          32'h2AAA_AAAA,  32'd2,          1'b0, 34}
      };
`endif
      #2;
      chk("reset busy", 32'(busy), 0);
      chk("reset done", 32'(done), 0);
      chk("reset quotient", quo, 0);
      chk("reset remainder", rem, 0);
      chk("reset div_zero", 32'(dz), 0);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      foreach (vecs[i]) begin
         launch(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z);
         chk($sformatf("vec%0d busy after start", i), 32'(busy), 32'(vecs[i].lat > 1));
         wait_done(vecs[i].lat, 1, $sformatf("vec%0d", i));
      end

      launch(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
      repeat (9) @(posedge clk);
      #1;
      dvd   = 32'd50;
      dsr   = 32'd3;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(34, 11, "ignored start");

      launch(32'd200, 32'd9, 32'd22, 32'd2, 1'b0);
      repeat (14) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("midreset busy", 32'(busy), 0);
      chk("midreset done", 32'(done), 0);
      chk("midreset quotient", quo, 0);
      chk("midreset remainder", rem, 0);
      chk("midreset div_zero", 32'(dz), 0);
      void'(sb.pop_back());
      @(posedge clk);
      #1 rst_n = 1'b1;
      seen = 0;
      repeat (40) begin
         @(posedge clk);
         #1 if (done) seen++;
      end
      chk("no done after reset", seen, 0);
      launch(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
      wait_done(34, 1, "after reset");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
